mult_div_unit: RTL

Multi-cycle multiply/divide unit for the single-cycle MIPS datapath. It takes over MULT, MULTU, DIV, DIVU, MTHI and MTLO from the combinational ALU, whose own multiply path is not used for these instructions. Results go into architectural HI/LO registers, which the datapath reads for MFHI/MFLO. The datapath issues a request with a start/busy/done handshake and stalls while `o_busy` is high.

---
 rtl/mult_div_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers.
// Magnitudes are iterated one bit per cycle; signs are applied in a single FIX cycle.
module mult_div_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [1:0]       i_op,
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic             i_mthi,
  input  logic             i_mtlo,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
  typedef enum logic [1:0] {OP_MULTU, OP_MULT, OP_DIVU, OP_DIV} op_t;

  state_t             state, state_nxt;
  op_t                op;
  logic               sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   rem;
  logic [CW-1:0]      cnt;
  logic [WIDTH-1:0]   hi, lo;

  logic               accept, last_iter;
  logic [WIDTH-1:0]   in_mag_a, in_mag_b;
  logic [WIDTH:0]     mul_sum, div_shift;
  logic               div_ge;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix, a_orig;

  always_comb begin
    accept    = i_start && (state == IDLE || state == DONE);
    last_iter = (cnt == CW'(WIDTH - 1));
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (last_iter) state_nxt = FIX;
      FIX:     state_nxt = DONE;
      DONE:    state_nxt = accept ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
    o_busy = (state == RUN) || (state == FIX);
    o_done = (state == DONE);
    o_hi   = hi;
    o_lo   = lo;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  // Shift-add keeps the product in acc: upper half accumulates, lower half
  // drains the multiplier. Division reuses acc's lower half as dividend/quotient.
  always_comb begin
    in_mag_a  = (i_op[0] && i_op_a[WIDTH-1]) ? -i_op_a : i_op_a;
    in_mag_b  = (i_op[0] && i_op_b[WIDTH-1]) ? -i_op_b : i_op_b;
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    div_shift = {rem, acc[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mag_b};
    prod_fix  = (op == OP_MULT && (sign_a ^ sign_b)) ? -acc : acc;
    quo_fix   = (op == OP_DIV && (sign_a ^ sign_b)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix   = (op == OP_DIV && sign_a) ? -rem : rem;
    a_orig    = (op == OP_DIV && sign_a) ? -mag_a : mag_a;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      op     <= OP_MULTU;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      acc    <= '0;
      rem    <= '0;
      cnt    <= '0;
      hi     <= '0;
      lo     <= '0;
    end else if (accept) begin
      op     <= op_t'(i_op);
      sign_a <= i_op[0] & i_op_a[WIDTH-1];
      sign_b <= i_op[0] & i_op_b[WIDTH-1];
      mag_a  <= in_mag_a;
      mag_b  <= in_mag_b;
      acc    <= i_op[1] ? {{WIDTH{1'b0}}, in_mag_a} : {{WIDTH{1'b0}}, in_mag_b};
      rem    <= '0;
      cnt    <= '0;
    end else begin
      case (state)
        RUN: begin
          cnt <= cnt + 1'b1;
          if (!op[1]) begin
            acc <= {mul_sum, acc[WIDTH-1:1]};
          end else begin
            rem             <= div_ge ? WIDTH'(div_shift - {1'b0, mag_b}) : div_shift[WIDTH-1:0];
            acc[WIDTH-1:0]  <= {acc[WIDTH-2:0], div_ge};
          end
        end
        FIX: begin
          if (!op[1]) begin
            {hi, lo} <= prod_fix;
          end else if (mag_b == '0) begin
            hi <= a_orig;
            lo <= '1;
          end else begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
        default: begin
          if (i_mthi) hi <= i_op_a;
          if (i_mtlo) lo <= i_op_a;
        end
      endcase
    end
  end

endmodule
